// File: rtl/alu_shift_pkg.sv
// Shared opcode and shift-mode encodings for the pipelined ALU + shifter.
package alu_shift_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_INC = 3'b010;
  localparam logic [2:0] OP_DEC = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_NOT = 3'b111;

  localparam logic [1:0] SH_PASS = 2'b00;
  localparam logic [1:0] SH_LSR  = 2'b01;
  localparam logic [1:0] SH_LSL  = 2'b10;
  localparam logic [1:0] SH_ROR  = 2'b11;

endpackage

// File: rtl/barrel_shift.sv
// Combinational shifter: pass, logical right/left, rotate right by a variable amount.
module barrel_shift
  import alu_shift_pkg::*;
#(
  parameter int WIDTH = 4,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] data,
  input  logic [1:0]       H,
  input  logic [SHW-1:0]   SHAMT,
  output logic [WIDTH-1:0] O
);

  logic             in_range;
  logic [SHW-1:0]   rot_amt;
  logic [2*WIDTH-1:0] dbl;

  always_comb begin
    // Only reachable when WIDTH is not a power of two.
    in_range = 32'(SHAMT) < WIDTH;
    rot_amt  = SHW'(32'(SHAMT) % WIDTH);
    dbl      = {data, data} >> rot_amt;
    O        = data;
    case (H)
      SH_LSR:  O = in_range ? (data >> SHAMT) : '0;
      SH_LSL:  O = in_range ? (data << SHAMT) : '0;
      SH_ROR:  O = dbl[WIDTH-1:0];
      default: O = data;
    endcase
  end

endmodule

// File: rtl/alu_shift_pipe.sv
// Two-stage pipelined ALU (stage 1) + barrel shifter (stage 2) with valid/ready on both sides.
module alu_shift_pipe
  import alu_shift_pkg::*;
#(
  parameter int WIDTH = 4,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       S,
  input  logic             Cin,
  input  logic [1:0]       H,
  input  logic [SHW-1:0]   SHAMT,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] F,
  output logic [WIDTH-1:0] O,
  output logic             Cout,
  output logic             Z,
  output logic             V
);

  localparam int MSB = WIDTH - 1;

  // Handshake: a transfer happens on any cycle where valid && ready are both high;
  // a stage advances when it is empty or the stage after it advances, so in_ready
  // depends only on stage state and out_ready, never on in_valid.
  logic adv1, adv2;
  logic s1_valid, s2_valid;

  assign adv2      = !s2_valid || out_ready;
  assign adv1      = !s1_valid || adv2;
  assign in_ready  = adv1;
  assign out_valid = s2_valid;

  logic [WIDTH:0]   alu_sum;
  logic [WIDTH-1:0] alu_b;
  logic             alu_c;
  logic             is_arith;
  logic             alu_v;

  always_comb begin
    alu_b    = '0;
    alu_c    = 1'b0;
    is_arith = 1'b1;
    alu_sum  = '0;
    // Arithmetic ops are all A + b + c with the effective b and carry chosen per op.
    case (S)
      OP_ADD: begin alu_b = B;             alu_c = Cin;  end
      OP_SUB: begin alu_b = ~B;            alu_c = Cin;  end
      OP_INC: begin alu_b = WIDTH'(1);     alu_c = 1'b0; end
      OP_DEC: begin alu_b = ~(WIDTH'(1));  alu_c = 1'b1; end
      default: is_arith = 1'b0;
    endcase
    if (is_arith) begin
      alu_sum = {1'b0, A} + {1'b0, alu_b} + {{WIDTH{1'b0}}, alu_c};
    end else begin
      case (S)
        OP_AND:  alu_sum = {1'b0, A & B};
        OP_OR:   alu_sum = {1'b0, A | B};
        OP_XOR:  alu_sum = {1'b0, A ^ B};
        default: alu_sum = {1'b0, ~A};
      endcase
    end
    alu_v = is_arith && (A[MSB] == alu_b[MSB]) && (alu_sum[MSB] != A[MSB]);
  end

  logic [WIDTH-1:0] s1_f;
  logic             s1_cout, s1_v;
  logic [1:0]       s1_h;
  logic [SHW-1:0]   s1_shamt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_f     <= '0;
      s1_cout  <= 1'b0;
      s1_v     <= 1'b0;
      s1_h     <= '0;
      s1_shamt <= '0;
    end else if (adv1) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_f     <= alu_sum[WIDTH-1:0];
        s1_cout  <= alu_sum[WIDTH];
        s1_v     <= alu_v;
        s1_h     <= H;
        s1_shamt <= SHAMT;
      end
    end
  end

  logic [WIDTH-1:0] shift_o;

  barrel_shift #(.WIDTH(WIDTH)) u_shift (
    .data  (s1_f),
    .H     (s1_h),
    .SHAMT (s1_shamt),
    .O     (shift_o)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s2_valid <= 1'b0;
      F        <= '0;
      O        <= '0;
      Cout     <= 1'b0;
      Z        <= 1'b0;
      V        <= 1'b0;
    end else if (adv2) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        F    <= s1_f;
        O    <= shift_o;
        Cout <= s1_cout;
        Z    <= (shift_o == '0);
        V    <= s1_v;
      end
    end
  end

endmodule

// File: tb/tb_alu_shift_pipe.sv
// Self-checking bench for alu_shift_pipe at WIDTH=8: directed vectors, backpressure, reset, random traffic.
module tb_alu_shift_pipe;
  import alu_shift_pkg::*;

  localparam int W    = 8;
  localparam int SHW  = 3;
  localparam int EW   = 2 * W + 3;
  localparam int MASK = (1 << W) - 1;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   A = '0, B = '0;
  logic [2:0]     S = '0;
  logic           Cin = 1'b0;
  logic [1:0]     H = '0;
  logic [SHW-1:0] SHAMT = '0;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [W-1:0]   F, O;
  logic           Cout, Z, V;

  alu_shift_pipe #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .S(S), .Cin(Cin), .H(H), .SHAMT(SHAMT),
    .out_valid(out_valid), .out_ready(out_ready),
    .F(F), .O(O), .Cout(Cout), .Z(Z), .V(V)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];
  logic [W-1:0]  got_o[$];
  bit            hold_valid = 1'b0;
  logic [EW-1:0] hold_val;
  logic [EW-1:0] act_vec;
  bit            done = 1'b0;

  assign act_vec = {F, O, Cout, Z, V};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic, signed range test for overflow.
  function automatic logic [EW-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [2:0] s, input logic cin,
                                          input logic [1:0] h, input logic [SHW-1:0] sh);
    int ua, ub, sa, sb, u, sr, ci;
    bit arith;
    logic [W-1:0] f, o;
    logic c, v;
    ua = a; ub = b; sa = $signed(a); sb = $signed(b); ci = cin;
    arith = 1'b1; u = 0; sr = 0;
    case (s)
      3'd0: begin u = ua + ub + ci;          sr = sa + sb + ci;     end
      3'd1: begin u = ua + (MASK - ub) + ci; sr = sa - sb - 1 + ci; end
      3'd2: begin u = ua + 1;                sr = sa + 1;           end
      3'd3: begin u = ua + MASK;             sr = sa - 1;           end
      3'd4: begin u = ua & ub;  arith = 1'b0; end
      3'd5: begin u = ua | ub;  arith = 1'b0; end
      3'd6: begin u = ua ^ ub;  arith = 1'b0; end
      default: begin u = MASK - ua; arith = 1'b0; end
    endcase
    f = W'(u);
    c = arith && (u > MASK);
    v = arith && (sr > MASK / 2 || sr < -(MASK / 2) - 1);
    case (h)
      2'd0: o = f;
      2'd1: o = f >> sh;
      2'd2: o = f << sh;
      default: begin
        o = f;
        for (int k = 0; k < int'(sh); k++) o = {o[0], o[W-1:1]};
      end
    endcase
    return {f, o, c, (o == '0), v};
  endfunction

  // scoreboard: one compare process at the falling edge
  always @(negedge clk) begin
    if (reset) begin
      if (hold_valid) check("hold_stable", {out_valid, act_vec}, {1'b1, hold_val});
      hold_valid = out_valid && !out_ready;
      hold_val   = act_vec;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL spurious_out actual=%h required=none", act_vec);
        end else begin
          check("result", act_vec, exp_q.pop_front());
        end
        got_o.push_back(O);
      end
      if (in_valid && in_ready) exp_q.push_back(model(A, B, S, Cin, H, SHAMT));
    end
  end

  // driver tasks
  task automatic set_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] s,
                        input logic cin, input logic [1:0] h, input logic [SHW-1:0] sh);
    A = a; B = b; S = s; Cin = cin; H = h; SHAMT = sh;
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] s,
                      input logic cin, input logic [1:0] h, input logic [SHW-1:0] sh);
    int n;
    n = 0;
    set_op(a, b, s, cin, h, sh);
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout actual=in_ready_low required=accept");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic directed(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2:0] s, input logic cin, input logic [1:0] h,
                          input logic [SHW-1:0] sh, input logic [EW-1:0] exp);
    @(posedge clk); #1;
    set_op(a, b, s, cin, h, sh);
    in_valid = 1'b1;
    @(negedge clk);
    check({name, "_in_ready"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({name, "_lat1"}, out_valid, 0);
    @(posedge clk); #1;
    check({name, "_lat2"}, {out_valid, act_vec}, {1'b1, exp});
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || out_valid) && n < 200) begin
      n++;
      @(posedge clk); #1;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    // model pinned against hand-computed literals
    check("model_add",  model(8'h05, 8'h03, OP_ADD, 1'b0, SH_PASS, 3'd0), {8'h08, 8'h08, 3'b000});
    check("model_wrap", model(8'hFF, 8'h01, OP_ADD, 1'b0, SH_PASS, 3'd0), {8'h00, 8'h00, 3'b110});
    check("model_sub",  model(8'h80, 8'h01, OP_SUB, 1'b1, SH_LSR,  3'd1), {8'h7F, 8'h3F, 3'b101});
    check("model_ror",  model(8'h81, 8'hFF, OP_AND, 1'b0, SH_ROR,  3'd1), {8'h81, 8'hC0, 3'b000});
    check("model_dec0", model(8'h00, 8'h00, OP_DEC, 1'b0, SH_LSL,  3'd4), {8'hFF, 8'hF0, 3'b000});

    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {out_valid, act_vec}, '0);
    check("reset_in_ready", in_ready, 1);
    @(negedge clk);
    reset = 1'b1;

    directed("add",  8'h05, 8'h03, OP_ADD, 1'b0, SH_PASS, 3'd0, {8'h08, 8'h08, 3'b000});
    directed("wrap", 8'hFF, 8'h01, OP_ADD, 1'b0, SH_PASS, 3'd0, {8'h00, 8'h00, 3'b110});
    directed("sub",  8'h80, 8'h01, OP_SUB, 1'b1, SH_LSR,  3'd1, {8'h7F, 8'h3F, 3'b101});
    directed("ror",  8'h81, 8'hFF, OP_AND, 1'b0, SH_ROR,  3'd1, {8'h81, 8'hC0, 3'b000});
    directed("lsl",  8'h0F, 8'h00, OP_NOT, 1'b0, SH_LSL,  3'd3, {8'hF0, 8'h80, 3'b000});
    drain();

    // backpressure: two ops fill the pipe, the third must wait
    out_ready = 1'b0;
    got_o.delete();
    send(8'h01, 8'h00, OP_ADD, 1'b0, SH_PASS, 3'd0);
    send(8'h02, 8'h00, OP_ADD, 1'b0, SH_PASS, 3'd0);
    set_op(8'h03, 8'h00, OP_ADD, 1'b0, SH_PASS, 3'd0);
    in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("bp_in_ready", in_ready, 0);
      check("bp_hold_o", {out_valid, O}, {1'b1, 8'h01});
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(8'h03, 8'h00, OP_ADD, 1'b0, SH_PASS, 3'd0);
    drain();
    check("bp_count", got_o.size(), 3);
    for (int k = 0; k < 3; k++) check("bp_order", got_o[k], k + 1);

    // reset with both stages occupied
    out_ready = 1'b0;
    send(8'h11, 8'h22, OP_XOR, 1'b0, SH_PASS, 3'd0);
    send(8'h40, 8'h40, OP_ADD, 1'b0, SH_PASS, 3'd0);
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    check("rst_async", {out_valid, act_vec}, '0);
    exp_q.delete();
    hold_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("rst_no_out", out_valid, 0);
    end
    directed("post_rst", 8'h10, 8'h20, OP_OR, 1'b0, SH_LSR, 3'd4, {8'h30, 8'h03, 3'b000});
    drain();

    // random traffic with random backpressure
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          send(W'($urandom), W'($urandom), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
               2'($urandom_range(0, 3)), SHW'($urandom_range(0, 7)));
          if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
          end
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
